// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: forwarding selects and
// shadow copies of the EX/MEM/WB pipeline-register fields.
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wreg;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
    } ex_shadow_t;

    typedef struct packed {
        logic [4:0] wreg;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
    } mem_shadow_t;

    typedef struct packed {
        logic [4:0] wreg;
        logic       regwrite;
    } wb_shadow_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side inputs and pipeline-control outputs of the
// hazard controller, grouped as one bundle.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       id_wreg;
    logic             id_regwrite;
    logic             id_memtoreg;
    logic             id_memwrite;
    logic             id_jump;
    logic             ex_branch_taken;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             load_use_stall;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg,
        output id_regwrite, id_memtoreg, id_memwrite, id_jump,
        output ex_branch_taken, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, fwd_a, fwd_b,
        input  load_use_stall, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg,
        input  id_regwrite, id_memtoreg, id_memwrite, id_jump,
        input  ex_branch_taken, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, fwd_a, fwd_b,
        output load_use_stall, stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// One EX operand forwarding select; the youngest producer
// (MEM) wins and $0 is never forwarded.
module fwd_sel
    import mips_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_wreg,
    input  logic       mem_regwrite,
    input  logic       mem_memtoreg,
    input  wb_shadow_t wb,
    output logic [1:0] sel
);

    // MEM ALU result first, then WB write data, else register file
    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && !mem_memtoreg &&
            mem_wreg != REG_ZERO && mem_wreg == src)
            sel = FWD_MEM;
        else if (wb.regwrite && wb.wreg != REG_ZERO &&
                 wb.wreg == src)
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB write fields,
// drives stalls, flushes, forwarding and a stall counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    ex_shadow_t  ex_q;
    mem_shadow_t mem_q;
    wb_shadow_t  wb_q;
    ex_shadow_t  ex_d;

    logic             mem_stall;
    logic             load_use;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             lus;
    logic [CNT_W-1:0] cnt_q;

    // Hazard detection from ID decode and the shadow state
    always_comb begin
        mem_stall = (mem_q.memtoreg | mem_q.memwrite)
                    & ~hz.mem_ready;
        load_use  = ex_q.memtoreg & ex_q.regwrite
                    & (ex_q.wreg != REG_ZERO)
                    & ((hz.id_use_rs & (hz.id_rs == ex_q.wreg))
                     | (hz.id_use_rt & (hz.id_rt == ex_q.wreg)));
    end

    // Prioritised enables and flushes; freeze beats everything
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        lus        = 1'b0;
        if (mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (hz.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            lus        = 1'b1;
        end else if (hz.id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    // Next EX shadow: the ID decode fields, or a bubble on flush
    always_comb begin
        ex_d          = '0;
        if (!idex_flush) begin
            ex_d.rs       = hz.id_rs;
            ex_d.rt       = hz.id_rt;
            ex_d.wreg     = hz.id_wreg;
            ex_d.regwrite = hz.id_regwrite;
            ex_d.memtoreg = hz.id_memtoreg;
            ex_d.memwrite = hz.id_memwrite;
        end
    end

    // Shadow registers advance with the real pipeline enables
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            if (idex_en)
                ex_q <= ex_d;
            if (exmem_en)
                mem_q <= '{wreg:     ex_q.wreg,
                           regwrite: ex_q.regwrite,
                           memtoreg: ex_q.memtoreg,
                           memwrite: ex_q.memwrite};
            if (memwb_en)
                wb_q <= '{wreg:     mem_q.wreg,
                          regwrite: mem_q.regwrite};
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (!pc_en && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

    fwd_sel u_fwd_a (
        .src          (ex_q.rs),
        .mem_wreg     (mem_q.wreg),
        .mem_regwrite (mem_q.regwrite),
        .mem_memtoreg (mem_q.memtoreg),
        .wb           (wb_q),
        .sel          (hz.fwd_a)
    );

    fwd_sel u_fwd_b (
        .src          (ex_q.rt),
        .mem_wreg     (mem_q.wreg),
        .mem_regwrite (mem_q.regwrite),
        .mem_memtoreg (mem_q.memtoreg),
        .wb           (wb_q),
        .sel          (hz.fwd_b)
    );

    assign hz.pc_en          = pc_en;
    assign hz.ifid_en        = ifid_en;
    assign hz.idex_en        = idex_en;
    assign hz.exmem_en       = exmem_en;
    assign hz.memwb_en       = memwb_en;
    assign hz.ifid_flush     = ifid_flush;
    assign hz.idex_flush     = idex_flush;
    assign hz.load_use_stall = lus;
    assign hz.stall_cycles   = cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core (IF/ID/EX/MEM/WB) supporting addu/subu/ori/lui/lw/sw/beq/j. It takes the ID-stage decode outputs of the control unit and keeps its own shadow copy of the destination-register and write-control fields for the EX, MEM and WB stages. From these it generates:

- pipeline-register enables and flushes;
- load-use stalls;
- beq/j flushes;
- EX-stage forwarding selects;
- a stall-cycle counter.

It turns the current hazard-free pipeline into one that runs arbitrary programs correctly.

## Interface

Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports (clock and reset first):
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs, id_rt  in  5  source register fields of the instruction in ID
- id_use_rs, id_use_rt  in  1  instruction in ID actually reads rs / rt
- id_wreg  in  5  destination after the RegDst mux (rd or rt)
- id_regwrite, id_memtoreg, id_memwrite  in  1  decode controls of the instruction in ID
- id_jump  in  1  j in ID
- ex_branch_taken  in  1  beq in EX with ALU zero=1
- mem_ready  in  1  data memory accepts/returns this cycle; tie to 1 for single-cycle memory
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register write enables
- ifid_flush, idex_flush  out  1  load a bubble (all-zero controls) into that register
- fwd_a, fwd_b  out  2  EX operand source: 00 register file, 01 WB write data, 10 MEM ALU result
- load_use_stall  out  1  status: load-use bubble inserted this cycle
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

## Operation

Internal state mirrors the pipeline registers:
- EX: {rs, rt, wreg, regwrite, memtoreg, memwrite}
- MEM: {wreg, regwrite, memtoreg, memwrite}
- WB: {wreg, regwrite}

A bubble is all fields zero. State advances exactly as the real registers do, using the same enables and flushes.

Hazard conditions:
- mem_stall = (mem_memtoreg | mem_memwrite) & ~mem_ready.
- load_use = ex_memtoreg & ex_regwrite & ex_wreg≠0 & ((id_use_rs & id_rs==ex_wreg) | (id_use_rt & id_rt==ex_wreg)).

Priority (highest first):
- mem_stall: all five enables 0, no flushes, state frozen.
- ex_branch_taken: all enables 1, ifid_flush=1, idex_flush=1. The instruction in ID is on the wrong path, so load_use and id_jump are ignored.
- load_use: pc_en=0, ifid_en=0, idex_flush=1, others enabled. The EX shadow becomes a bubble.
- id_jump: all enables 1, ifid_flush=1.
- none of the above: all enables 1, no flushes.

Forwarding (computed per operand; fwd_a uses ex_rs, fwd_b uses ex_rt):
- Select 10 if mem_regwrite & ~mem_memtoreg & mem_wreg≠0 & mem_wreg==src.
- Otherwise select 01 if wb_regwrite & wb_wreg≠0 & wb_wreg==src.
- Otherwise select 00.
- MEM takes priority over WB (youngest producer wins).
- $0 is never forwarded.
- A load in MEM matching src is unreachable because load_use prevents it; the bench asserts this.
- WB→ID hazards are not handled here. The register file is write-before-read within a cycle.

stall_cycles:
- Increments on every cycle with pc_en=0.
- Saturates at all-ones.
- Cleared only by reset.

## Timing

- Hazard outputs (enables, flushes, load_use_stall) are combinational from the ID inputs, ex_branch_taken, mem_ready and the shadow state. There is no registered latency.
- fwd_a/fwd_b are combinational from the shadow state only.
- A load-use costs exactly 1 bubble.
- beq taken costs 2 flushed slots.
- j costs 1 flushed slot.
- mem_stall lasts as long as mem_ready=0. There is no limit.
- Reset cycle and the cycle after: shadow state all bubbles, enables 1, flushes 0, fwd 00, load_use_stall 0, stall_cycles 0.
- Reset asserted mid-stall clears the state on the next edge. The pending stall is discarded.
- Simultaneous mem_stall and branch_taken: the freeze wins. The flush takes effect on the first cycle with mem_ready=1, because the branch stays in EX.

## Structure

- Shared package mips_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_ZERO=5'd0
  - a shadow-stage struct per stage
- Sub-module fwd_sel computes one 2-bit select from {src, mem fields, wb fields}. It is instantiated twice (A and B).

## Test plan

- lw $1,0($0); addu $2,$1,$1 → one cycle with pc_en=0, idex_flush=1, load_use_stall=1; next cycle fwd_a=fwd_b=01; stall_cycles=1.
- ori $3,$0,5; addu $4,$3,$3 → no stall; fwd_a=fwd_b=10 when addu is in EX.
- addu $5,..; ori $6,..; subu $7,$5,$6 → in EX: fwd_a=01, fwd_b=10; a write to $0 followed by a read of $0 gives fwd 00.
- beq taken, with a dependent lw-use pair behind it → ifid_flush=idex_flush=1 for one cycle; load_use_stall=0; pc_en=1.
- j then sw → ifid_flush=1 for one cycle; sw reaches MEM with mem_ready held 0 for 3 cycles → all enables 0 for those 3 cycles; stall_cycles +3.
- reset asserted during mem_stall → next cycle all enables 1, fwd 00, stall_cycles 0.
